b16_mem_arbiter: RTL and testbench

Shares the single b16 memory port between the cpu core and one DMA master. The CPU owns the bus by default. A pending DMA request freezes the core by deasserting its `run` input at a clock boundary, then grants the bus to the DMA master for a bounded burst. After the burst, the CPU is guaranteed a minimum number of bus cycles. The block sits between the cpu/debugger pair and the asynchronous-read program/data SRAM.

---
 rtl/b16_mem_arbiter.sv | 102 ++++++++++
 tb/tb_b16_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b16_mem_arbiter.sv
// Memory-port arbiter between the b16 cpu core and a single DMA master.
// The CPU owns the bus by default; DMA bursts freeze the core via cpu_run.
module b16_mem_arbiter #(
    parameter int unsigned BURST   = 8,
    parameter int unsigned MIN_CPU = 2,
    parameter int unsigned l       = 16
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         ext_run,
    output logic         cpu_run,
    input  logic [l-1:0] cpu_addr,
    input  logic         cpu_rd,
    input  logic [1:0]   cpu_wr,
    input  logic [l-1:0] cpu_wdata,
    output logic [l-1:0] cpu_rdata,
    input  logic         dma_req,
    input  logic         dma_we,
    input  logic [1:0]   dma_be,
    input  logic [l-1:0] dma_addr,
    input  logic [l-1:0] dma_wdata,
    output logic         dma_ack,
    output logic [l-1:0] dma_rdata,
    output logic         dma_gnt,
    output logic [l-1:0] mem_addr,
    output logic         mem_rd,
    output logic [1:0]   mem_wr,
    output logic [l-1:0] mem_wdata,
    input  logic [l-1:0] mem_rdata
);

    typedef enum logic {StCpu, StDma} state_e;

    localparam logic [7:0] LastWord = 8'(BURST - 1);
    localparam logic [7:0] HoldInit = 8'(MIN_CPU);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StCpu;
            cnt_q   <= 8'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Read data is shared; consumers qualify it with their own handshake.
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        mem_addr  = cpu_addr;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_wdata;
        cpu_run   = ext_run;
        dma_ack   = 1'b0;
        dma_gnt   = 1'b0;

        unique case (state_q)
            StCpu: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (dma_req) begin
                    state_d = StDma;
                    cnt_d   = 8'd0;
                end
            end
            StDma: begin
                mem_addr  = dma_addr;
                mem_rd    = dma_req & ~dma_we;
                mem_wr    = (dma_req & dma_we) ? dma_be : 2'b00;
                mem_wdata = dma_wdata;
                cpu_run   = 1'b0;
                dma_gnt   = 1'b1;
                dma_ack   = dma_req;
                if (!dma_req) begin
                    state_d = StCpu;
                    hold_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Burst limit reached: hand back and guarantee CPU cycles.
                    if (cnt_q == LastWord) begin
                        state_d = StCpu;
                        hold_d  = HoldInit;
                    end
                end
            end
            default: state_d = StCpu;
        endcase
    end

endmodule

// File: tb/tb_b16_mem_arbiter.sv
// Randomized bench for b16_mem_arbiter against a burst/cool-down model
// and a local asynchronous-read SRAM.
module tb_b16_mem_arbiter;

    localparam int BURST   = 8;
    localparam int MIN_CPU = 2;

    logic        clk = 1'b0;
    logic        nreset;
    logic        ext_run;
    logic        cpu_run;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rd;
    logic [1:0]  cpu_wr;
    logic        dma_req, dma_we, dma_ack, dma_gnt;
    logic [1:0]  dma_be;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd;
    logic [1:0]  mem_wr;

    logic [15:0] sram [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: are we in a DMA grant, words acked so far, CPU cycles still owed.
    bit m_dma     = 1'b0;
    int m_words   = 0;
    int m_wait    = 0;
    bit last_ack  = 1'b0;

    always #5 clk = ~clk;

    b16_mem_arbiter #(
        .BURST  (BURST),
        .MIN_CPU(MIN_CPU),
        .l      (16)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .ext_run  (ext_run),
        .cpu_run  (cpu_run),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_be   (dma_be),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_ack  (dma_ack),
        .dma_rdata(dma_rdata),
        .dma_gnt  (dma_gnt),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = sram[mem_addr[10:1]];

    always @(posedge clk) begin
        if (mem_wr[0]) sram[mem_addr[10:1]][7:0]  <= mem_wdata[7:0];
        if (mem_wr[1]) sram[mem_addr[10:1]][15:8] <= mem_wdata[15:8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_cpu(input bit allow_wr);
        cpu_addr  = 16'($urandom);
        cpu_rd    = 1'($urandom);
        cpu_wr    = allow_wr ? 2'($urandom) : 2'b00;
        cpu_wdata = 16'($urandom);
    endtask

    // Check one cycle's outputs at the falling edge, then advance the model.
    task automatic cycle();
        @(negedge clk);
        if (m_dma) begin
            check("dma_gnt", 32'(dma_gnt), 32'd1);
            check("cpu_run", 32'(cpu_run), 32'd0);
            check("dma_ack", 32'(dma_ack), 32'(dma_req));
            check("mem_addr", 32'(mem_addr), 32'(dma_addr));
            check("mem_rd", 32'(mem_rd), 32'(dma_req & ~dma_we));
            check("mem_wr", 32'(mem_wr), (dma_req && dma_we) ? 32'(dma_be) : 32'd0);
            check("mem_wdata", 32'(mem_wdata), 32'(dma_wdata));
            if (dma_req && !dma_we)
                check("dma_rdata", 32'(dma_rdata), 32'(sram[dma_addr[10:1]]));
        end else begin
            check("dma_gnt", 32'(dma_gnt), 32'd0);
            check("cpu_run", 32'(cpu_run), 32'(ext_run));
            check("dma_ack", 32'(dma_ack), 32'd0);
            check("mem_addr", 32'(mem_addr), 32'(cpu_addr));
            check("mem_rd", 32'(mem_rd), 32'(cpu_rd));
            check("mem_wr", 32'(mem_wr), 32'(cpu_wr));
            check("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
            check("cpu_rdata", 32'(cpu_rdata), 32'(sram[cpu_addr[10:1]]));
        end
        last_ack = m_dma && dma_req;
        if (m_dma) begin
            if (!dma_req) begin
                m_dma  = 1'b0;
                m_wait = 0;
            end else begin
                m_words++;
                if (m_words == BURST) begin
                    m_dma  = 1'b0;
                    m_wait = MIN_CPU;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (dma_req) begin
            m_dma   = 1'b1;
            m_words = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit allow_wr);
        dma_req = 1'b0;
        repeat (n) begin
            rand_cpu(allow_wr);
            cycle();
        end
    endtask

    // Issue n consecutive words; returns cycles from request to last ack.
    task automatic run_dma(input int n, input bit we, input logic [1:0] be,
                           input logic [15:0] addr0, input logic [15:0] wd, output int cyc);
        int acks = 0;
        cyc       = 0;
        dma_req   = 1'b1;
        dma_we    = we;
        dma_be    = be;
        dma_addr  = addr0;
        dma_wdata = wd;
        while (acks < n && cyc < 200) begin
            rand_cpu(1'b0);
            cycle();
            cyc++;
            if (last_ack) begin
                acks++;
                dma_addr  = dma_addr + 16'd2;
                dma_wdata = dma_wdata + 16'd1;
            end
        end
        if (acks < n) check("dma_timeout", 32'(acks), 32'(n));
        dma_req = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) sram[i] = 16'($urandom);
        nreset    = 1'b0;
        ext_run   = 1'b1;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_be    = 2'b00;
        dma_addr  = 16'h0000;
        dma_wdata = 16'h0000;
        rand_cpu(1'b0);
        #1;
        check("rst_ack", 32'(dma_ack), 32'd0);
        check("rst_gnt", 32'(dma_gnt), 32'd0);
        check("rst_run", 32'(cpu_run), 32'd1);
        check("rst_maddr", 32'(mem_addr), 32'(cpu_addr));
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // CPU-only traffic from the reset vector region
        dma_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_cpu(1'b1);
            cpu_addr = 16'h3FFE + 16'(2 * i);
            cycle();
        end

        run_dma(3, 1'b0, 2'b00, 16'h0100, 16'h0000, cyc);
        check("rd3_cycles", 32'(cyc), 32'd4);
        idle(4, 1'b1);

        // 20 words: 1 grant-latency + 8 + 3 + 8 + 3 + 4
        run_dma(20, 1'b0, 2'b00, 16'h0040, 16'h0000, cyc);
        check("burst20_cycles", 32'(cyc), 32'd27);
        idle(4, 1'b0);

        run_dma(1, 1'b1, 2'b11, 16'h0200, 16'h1234, cyc);
        idle(3, 1'b0);
        run_dma(1, 1'b1, 2'b01, 16'h0200, 16'hABCD, cyc);
        idle(1, 1'b0);
        check("byte_write", 32'(sram[256]), 32'h0000_12CD);
        run_dma(1, 1'b0, 2'b00, 16'h0200, 16'h0000, cyc);
        idle(3, 1'b1);

        ext_run = 1'b0;
        run_dma(4, 1'b0, 2'b00, 16'h0300, 16'h0000, cyc);
        check("halt_burst_cycles", 32'(cyc), 32'd5);
        idle(4, 1'b1);
        ext_run = 1'b1;

        // Reset asserted during the second word; master reissues that word.
        dma_req   = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 16'h0080;
        cyc       = 0;
        while (!(m_dma && m_words == 1) && cyc < 20) begin
            cycle();
            cyc++;
            if (last_ack) dma_addr = dma_addr + 16'd2;
        end
        check("rst_mid_reached", 32'(m_dma && m_words == 1), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("rst_mid_ack", 32'(dma_ack), 32'd0);
        check("rst_mid_gnt", 32'(dma_gnt), 32'd0);
        check("rst_mid_run", 32'(cpu_run), 32'(ext_run));
        m_dma   = 1'b0;
        m_words = 0;
        m_wait  = 0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        run_dma(BURST, 1'b0, 2'b00, dma_addr, 16'h0000, cyc);
        check("rst_regrant_cycles", 32'(cyc), 32'(BURST + 1));
        idle(4, 1'b1);

        // Random mix of CPU traffic, debugger halts and DMA transactions
        last_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rand_cpu(1'b1);
            ext_run = ($urandom_range(0, 9) != 0);
            if (!dma_req || last_ack) begin
                if ($urandom_range(0, 99) < 40) begin
                    dma_req   = 1'b1;
                    dma_we    = 1'($urandom);
                    dma_be    = 2'($urandom);
                    dma_addr  = 16'($urandom);
                    dma_wdata = 16'($urandom);
                end else begin
                    dma_req = 1'b0;
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
